// File: rtl/la_axi_sram_slave.sv
// la_axi_sram_slave: AXI4 slave that serves one master port from an internal
// word-addressed SRAM. Independent read and write FSMs allow one outstanding
// transaction per direction.
// Optional feature: define LA_AXI_SRAM_STALL_EN to enable LFSR-driven
// backpressure on W and R, which makes the handshake timing pseudo-random.
module la_axi_sram_slave #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            ID_WIDTH   = 4,
  parameter int unsigned            DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // write address
  input  logic [ID_WIDTH-1:0]       aw_id,
  input  logic [ADDR_WIDTH-1:0]     aw_addr,
  input  logic [3:0]                aw_len,
  input  logic [1:0]                aw_burst,
  input  logic                      aw_valid,
  output logic                      aw_ready,
  // write data
  input  logic [DATA_WIDTH-1:0]     w_data,
  input  logic [DATA_WIDTH/8-1:0]   w_strb,
  input  logic                      w_last,
  input  logic                      w_valid,
  output logic                      w_ready,
  // write response
  output logic [ID_WIDTH-1:0]       b_id,
  output logic [1:0]                b_resp,
  output logic                      b_valid,
  input  logic                      b_ready,
  // read address
  input  logic [ID_WIDTH-1:0]       ar_id,
  input  logic [ADDR_WIDTH-1:0]     ar_addr,
  input  logic [3:0]                ar_len,
  input  logic [1:0]                ar_burst,
  input  logic                      ar_valid,
  output logic                      ar_ready,
  // read data
  output logic [ID_WIDTH-1:0]       r_id,
  output logic [DATA_WIDTH-1:0]     r_data,
  output logic [1:0]                r_resp,
  output logic                      r_last,
  output logic                      r_valid,
  input  logic                      r_ready
);

  localparam int unsigned STRB  = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(STRB);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] { W_IDLE, W_DATA, W_RESP } w_state_e;
  typedef enum logic       { R_IDLE, R_DATA }         r_state_e;

  // FIXED keeps the address; INCR and WRAP both step by one word.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [1:0]            burst);
    return (burst == 2'b00) ? a : a + ADDR_WIDTH'(STRB);
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic stall;

`ifdef LA_AXI_SRAM_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Free-running LFSR (taps 8,6,5,4) providing the stall pattern
  always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // LFSR register, seeded at reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 8'hA5;
    else        lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // ---------------------------------------------------------------- write
  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [3:0]            aw_len_q, aw_len_d;
  logic [1:0]            aw_burst_q, aw_burst_d;
  logic [3:0]            w_cnt_q, w_cnt_d;
  logic                  w_err_q, w_err_d;
  logic                  aw_ready_q, aw_ready_d;

  logic [ADDR_WIDTH-1:0] w_word;
  logic                  w_inrange;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_fire;

  assign w_word    = (aw_addr_q - BASE_ADDR) >> OFF_W;
  assign w_inrange = (w_word < ADDR_WIDTH'(DEPTH));
  assign w_idx     = w_word[IDX_W-1:0];

  assign aw_ready = aw_ready_q;
  assign w_ready  = (w_state_q == W_DATA) && !stall;
  assign w_fire   = w_valid && w_ready;
  assign b_valid  = (w_state_q == W_RESP);
  assign b_id     = aw_id_q;
  assign b_resp   = w_err_q ? RESP_SLVERR : RESP_OKAY;

  // Write FSM next-state: accept AW, count W beats, then hold B until taken
  always_comb begin
    w_state_d  = w_state_q;
    aw_id_d    = aw_id_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_burst_d = aw_burst_q;
    w_cnt_d    = w_cnt_q;
    w_err_d    = w_err_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_valid && aw_ready_q) begin
          aw_id_d    = aw_id;
          aw_addr_d  = aw_addr;
          aw_len_d   = aw_len;
          aw_burst_d = aw_burst;
          w_cnt_d    = '0;
          w_err_d    = 1'b0;
          w_state_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (w_fire) begin
          if (!w_inrange || (w_last != (w_cnt_q == aw_len_q))) w_err_d = 1'b1;
          // burst length is set by AW len, not by w_last
          if (w_cnt_q == aw_len_q) begin
            w_state_d = W_RESP;
          end else begin
            w_cnt_d   = w_cnt_q + 4'd1;
            aw_addr_d = next_addr(aw_addr_q, aw_burst_q);
          end
        end
      end
      W_RESP: begin
        if (b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    aw_ready_d = (w_state_d == W_IDLE);
  end

  // Write FSM state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q  <= W_IDLE;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_burst_q <= '0;
      w_cnt_q    <= '0;
      w_err_q    <= 1'b0;
      aw_ready_q <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      aw_id_q    <= aw_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_burst_q <= aw_burst_d;
      w_cnt_q    <= w_cnt_d;
      w_err_q    <= w_err_d;
      aw_ready_q <= aw_ready_d;
    end
  end

  // SRAM byte-lane write; contents are not reset
  always_ff @(posedge clk) begin
    if (w_fire && w_inrange) begin
      for (int unsigned b = 0; b < STRB; b++) begin
        if (w_strb[b]) mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read
  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [3:0]            r_len_q, r_len_d;
  logic [1:0]            r_burst_q, r_burst_d;
  logic [3:0]            r_cnt_q, r_cnt_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic [1:0]            r_resp_q, r_resp_d;
  logic                  r_last_q, r_last_d;
  logic                  r_valid_q, r_valid_d;
  logic                  ar_ready_q, ar_ready_d;

  logic [ADDR_WIDTH-1:0] r_word;
  logic                  r_inrange;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  r_fire;

  assign r_word    = (r_addr_q - BASE_ADDR) >> OFF_W;
  assign r_inrange = (r_word < ADDR_WIDTH'(DEPTH));
  assign r_idx     = r_word[IDX_W-1:0];
  // Read before the same-edge write lands, so a colliding beat sees old data
  assign rd_word   = mem[r_idx];

  assign ar_ready = ar_ready_q;
  assign r_id     = r_id_q;
  assign r_data   = r_data_q;
  assign r_resp   = r_resp_q;
  assign r_last   = r_last_q;
  assign r_valid  = r_valid_q;
  assign r_fire   = r_valid_q && r_ready;

  // Read FSM next-state: accept AR, then register one beat per free R slot
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_burst_d = r_burst_q;
    r_cnt_d   = r_cnt_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    r_last_d  = r_last_q;
    r_valid_d = r_valid_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_valid && ar_ready_q) begin
          r_id_d    = ar_id;
          r_addr_d  = ar_addr;
          r_len_d   = ar_len;
          r_burst_d = ar_burst;
          r_cnt_d   = '0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (r_fire && r_last_q) begin
          r_valid_d = 1'b0;
          r_state_d = R_IDLE;
        end else if ((!r_valid_q || r_fire) && !stall) begin
          // Load the next beat into an empty or just-emptied slot
          r_data_d  = r_inrange ? rd_word : '0;
          r_resp_d  = r_inrange ? RESP_OKAY : RESP_SLVERR;
          r_last_d  = (r_cnt_q == r_len_q);
          r_cnt_d   = r_cnt_q + 4'd1;
          r_addr_d  = next_addr(r_addr_q, r_burst_q);
          r_valid_d = 1'b1;
        end else if (r_fire) begin
          r_valid_d = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    ar_ready_d = (r_state_d == R_IDLE);
  end

  // Read FSM state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q  <= R_IDLE;
      r_id_q     <= '0;
      r_addr_q   <= '0;
      r_len_q    <= '0;
      r_burst_q  <= '0;
      r_cnt_q    <= '0;
      r_data_q   <= '0;
      r_resp_q   <= '0;
      r_last_q   <= 1'b0;
      r_valid_q  <= 1'b0;
      ar_ready_q <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      r_id_q     <= r_id_d;
      r_addr_q   <= r_addr_d;
      r_len_q    <= r_len_d;
      r_burst_q  <= r_burst_d;
      r_cnt_q    <= r_cnt_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      r_last_q   <= r_last_d;
      r_valid_q  <= r_valid_d;
      ar_ready_q <= ar_ready_d;
    end
  end

endmodule
